// File: rtl/apb_slave_ctrl.sv
// apb_slave_ctrl: APB4 slave front-end issuing single start pulses to the AXI-Lite control stage with timeout recovery
module apb_slave_ctrl #(
   parameter int AW_APB = 32,
   parameter int DW_APB = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  axi_clk,
   input  logic                  sys_aresetn,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [AW_APB-1:0]     paddr,
   input  logic [DW_APB-1:0]     pwdata,
   input  logic [DW_APB/8-1:0]   pstrb,
   input  logic [2:0]            pprot,
   output logic                  pready,
   output logic [DW_APB-1:0]     prdata,
   output logic                  pslverr,
   output logic                  start_write,
   output logic                  start_read,
   output logic [AW_APB-1:0]     address,
   output logic [DW_APB-1:0]     write_data,
   output logic [2:0]            prot,
   output logic [DW_APB/8-1:0]   be,
   input  logic [1:0]            resp,
   input  logic [DW_APB-1:0]     read_data,
   input  logic                  read_data_valid,
   input  logic                  done_write
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;
   state_t state, state_nxt;
   logic is_write, drain, err, done, tmo;
   logic [15:0] cnt;
   always_comb begin
      done = is_write ? done_write : read_data_valid;
      tmo = (TIMEOUT_CYCLES != 0) && (cnt == 16'(TIMEOUT_CYCLES - 1));
      state_nxt = (state == IDLE && psel)            ? ISSUE :
                  (state == ISSUE)                   ? WAIT :
                  (state == WAIT && (done || tmo))   ? RESP :
                  (state == RESP)                    ? (drain ? DRAIN : IDLE) :
                  (state == DRAIN && done)           ? IDLE : state;
      start_write = (state == ISSUE) && is_write;
      start_read = (state == ISSUE) && !is_write;
      pready = (state == RESP);
      pslverr = (state == RESP) && err;
   end
   always_ff @(posedge axi_clk or negedge sys_aresetn) begin
      if (!sys_aresetn) begin
         state <= IDLE;
         is_write <= 1'b0;
         drain <= 1'b0;
         err <= 1'b0;
         cnt <= '0;
         prdata <= '0;
         address <= '0;
         write_data <= '0;
         prot <= '0;
         be <= '0;
      end else begin
         state <= state_nxt;
         cnt <= (state == WAIT) ? cnt + 16'd1 : '0;
         if (state == IDLE && psel) begin
            address <= paddr;
            write_data <= pwdata;
            prot <= pprot;
            be <= pwrite ? pstrb : '1;
            is_write <= pwrite;
         end
         // completion takes priority over a coincident timeout, so no drain is armed
         if (state == WAIT && done) begin
            prdata <= is_write ? '0 : read_data;
            err <= |resp;
            drain <= 1'b0;
         end else if (state == WAIT && tmo) begin
            prdata <= '0;
            err <= 1'b1;
            drain <= 1'b1;
         end
         if (state == DRAIN && done) drain <= 1'b0;
      end
   end
endmodule
